// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_DM = 2'd2
  } arb_owner_t;

  // Memory is double-word addressed; byte-offset bits are dropped on the port.
  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/mem_lat_timer.sv
// rtl/mem_lat_timer.sv - load/decrement latency counter flagging the data-valid cycle
module mem_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for the shared single-port memory
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD       = 64,
  parameter int INST_SIZE  = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD-1:0]      if_addr,
  output logic [INST_SIZE-1:0] if_rdata,
  output logic                 if_valid,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [WORD-1:0]      dm_addr,
  input  logic [WORD-1:0]      dm_wdata,
  output logic [WORD-1:0]      dm_rdata,
  output logic                 dm_valid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WORD-1:0]      mem_addr,
  output logic [WORD-1:0]      mem_wdata,
  input  logic [WORD-1:0]      mem_rdata,
  output logic                 stall,
  output logic                 busy
);

  arb_state_t state;
  arb_state_t state_nxt;
  arb_owner_t owner;
  logic       if_hi;
  logic       grant_if;
  logic       grant_dm;
  logic       capture;
  logic       lat_last;
  logic       if_force;

  mem_lat_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_timer (
    .clk  (clk),
    .rst  (rst),
    .load (grant_if | grant_dm),
    .en   (state == ACCESS),
    .last (lat_last)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  // Counts IF losses to DM; once saturated, IF wins the next arbitration it joins.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && if_req && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign if_force = (starve_cnt == SW'(STARVE_MAX));
`else
  assign if_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || dm_req) state_nxt = ACCESS;
      ACCESS:  if (lat_last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        grant_if = if_req && (!dm_req || if_force);
        grant_dm = dm_req && !grant_if;
      end
      ACCESS:  capture = lat_last;
      default: ;
    endcase
  end

  // Port and response registers; the RESP edge releases ownership and the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= NONE;
      if_hi     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en   <= grant_if | grant_dm;
      if_valid <= capture && (owner == OWN_IF);
      dm_valid <= capture && (owner == OWN_DM);
      if (grant_if || grant_dm) begin
        owner     <= grant_dm ? OWN_DM : OWN_IF;
        if_hi     <= if_addr[2];
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= (grant_dm ? dm_addr : if_addr) & ALIGN_MASK[WORD-1:0];
        mem_wdata <= dm_wdata;
      end
      if (capture && (owner == OWN_IF)) begin
        if_rdata <= if_hi ? mem_rdata[2*INST_SIZE-1:INST_SIZE] : mem_rdata[INST_SIZE-1:0];
      end
      if (capture && (owner == OWN_DM) && !mem_we) begin
        dm_rdata <= mem_rdata;
      end
      if (state == RESP) begin
        owner  <= NONE;
        mem_we <= 1'b0;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        busy;

  logic [63:0] mem_img [0:63];
  logic [63:0] sb_mem  [0:63];
  logic [63:0] rd_q;
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [63:0] pre_val;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  mem_port_arbiter #(
    .WORD(64), .INST_SIZE(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(tb_clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .busy(busy)
  );

  // Memory model: read data is registered on mem_en and held until the next access.
  always @(posedge tb_clk) begin
    if (pre_en) begin
      mem_img[pre_idx] <= pre_val;
    end else if (mem_en) begin
      rd_q <= mem_img[mem_addr[8:3]];
      if (mem_we) mem_img[mem_addr[8:3]] <= mem_wdata;
    end
  end
  assign mem_rdata = rd_q;

  typedef struct {
    logic        is_if;
    logic        we;
    logic        pre;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] word;
    logic [63:0] exp_maddr;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [63:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    sb_mem[idx] = val;
    next_cycle();
    pre_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    if (v.pre) preload(v.exp_maddr[8:3], v.word);
    if (v.is_if) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      dm_req   = 1'b1;
      dm_we    = v.we;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      if (v.we) sb_mem[v.exp_maddr[8:3]] = v.wdata;
    end
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c == LAT + 2) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      @(negedge tb_clk);
      chk($sformatf("v%0d mem_en c%0d", n, c), mem_en, c == 1);
      chk($sformatf("v%0d busy c%0d", n, c), busy, (c >= 1) && (c <= LAT + 1));
      chk($sformatf("v%0d stall c%0d", n, c), stall, c <= LAT);
      chk($sformatf("v%0d if_valid c%0d", n, c), if_valid, v.is_if && (c == LAT + 1));
      chk($sformatf("v%0d dm_valid c%0d", n, c), dm_valid, !v.is_if && (c == LAT + 1));
      if (c == 1) begin
        chk($sformatf("v%0d mem_addr", n), mem_addr, v.exp_maddr);
        chk($sformatf("v%0d mem_we", n), mem_we, !v.is_if && v.we);
        if (!v.is_if && v.we) chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.wdata);
      end
      if (c == LAT + 1)
        chk($sformatf("v%0d rdata", n), v.is_if ? {32'h0, if_rdata} : dm_rdata, v.exp_rdata);
      next_cycle();
    end
  endtask

  int          en_c1, en_c2, dm_vc, if_vc, dm_cnt, if_cnt;
  int          gn;
  logic        gs [8];
  logic [5:0]  exp_seq;
  int          g, free_c, starve, idx;
  logic        g_if, g_we, force_if, e_en, e_busy, e_ifv, e_dmv, e_stall;
  logic [63:0] g_maddr, g_wdata, g_data, hold_dm, a;
  logic [31:0] hold_if;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 64'h10, 64'h0,  64'h45,                  64'h10, 64'h45};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 64'h20, 64'h99, 64'h0,                   64'h20, 64'h45};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 64'h20, 64'h0,  64'h0,                   64'h20, 64'h99};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 64'h4,  64'h0,  64'hF8408009_F8400009,   64'h0,  64'hF8408009};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,                   64'h0,  64'hF8400009};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 64'hC,  64'h0,  64'h11112222_33334444,   64'h8,  64'h11112222};

    for (int i = 0; i < 64; i++) preload(6'(i), {$urandom, $urandom});

    @(negedge tb_clk);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset if_rdata", {32'h0, if_rdata}, 0);
    chk("reset if_valid", if_valid, 0);
    chk("reset dm_rdata", dm_rdata, 0);
    chk("reset dm_valid", dm_valid, 0);
    chk("reset stall", stall, 0);
    chk("reset busy", busy, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Collision: DM store and IF fetch in the same cycle.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h20; dm_wdata = 64'h99;
    if_req = 1'b1; if_addr = 64'h8;
    sb_mem[4] = 64'h99;
    en_c1 = -1; en_c2 = -1; dm_vc = -1; if_vc = -1; dm_cnt = 0; if_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge tb_clk);
      if (mem_en) begin
        if (en_c1 < 0) begin
          en_c1 = c;
          chk("coll store addr", mem_addr, 64'h20);
          chk("coll store we", mem_we, 1);
          chk("coll store wdata", mem_wdata, 64'h99);
        end else if (en_c2 < 0) begin
          en_c2 = c;
          chk("coll fetch addr", mem_addr, 64'h8);
          chk("coll fetch we", mem_we, 0);
        end
      end
      if (dm_valid) begin dm_cnt++; dm_vc = c; end
      if (if_valid) begin if_cnt++; if_vc = c; end
      next_cycle();
      if (dm_vc == c) dm_req = 1'b0;
      if (if_vc == c) if_req = 1'b0;
    end
    chk("coll dm mem_en cycle", en_c1, 1);
    chk("coll if mem_en cycle", en_c2, LAT + 3);
    chk("coll dm_valid cycle", dm_vc, LAT + 1);
    chk("coll if_valid cycle", if_vc, 2 * LAT + 3);
    chk("coll dm_valid count", dm_cnt, 1);
    chk("coll if_valid count", if_cnt, 1);
    chk("coll dm_rdata held", dm_rdata, 64'h99);
    chk("coll if_rdata", {32'h0, if_rdata}, {32'h0, sb_mem[1][31:0]});

    // Requester drops its load after one cycle; the transaction still completes.
    preload(6'd3, 64'hABCD);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h18;
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c == 1) dm_req = 1'b0;
      @(negedge tb_clk);
      if (c == 1) chk("drop stall", stall, 0);
      chk($sformatf("drop dm_valid c%0d", c), dm_valid, c == LAT + 1);
      if (c == LAT + 1) chk("drop dm_rdata", dm_rdata, 64'hABCD);
      next_cycle();
    end

    // Reset during ACCESS abandons the load.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; dm_req = 1'b0;
    @(negedge tb_clk);
    chk("rst dm_valid", dm_valid, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst busy", busy, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    next_cycle();
    @(negedge tb_clk);
    chk("rst late dm_valid", dm_valid, 0);
    next_cycle();

    // Both requesters held high: grant order shows the priority policy.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
    if_req = 1'b1; if_addr = 64'h1C0;
    gn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge tb_clk);
      if (mem_en && gn < 8) begin
        gs[gn] = (mem_addr == 64'h1C0);
        gn++;
      end
      next_cycle();
    end
    dm_req = 1'b0; if_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    exp_seq = 6'b010000;
`else
    exp_seq = 6'b000000;
`endif
    chk("starve grant count", gn >= 6, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("starve grant %0d is_if", i), gs[i], exp_seq[i]);

    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Random traffic against a transaction-level model.
    g = -100; free_c = 0; starve = 0; g_if = 1'b0; g_we = 1'b0;
    g_maddr = '0; g_wdata = '0; g_data = '0; hold_if = '0; hold_dm = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 64'($urandom_range(0, 127)) * 4;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 64'($urandom_range(0, 63)) * 8;
        dm_wdata = {$urandom, $urandom};
      end
      if (c >= free_c && (if_req || dm_req)) begin
`ifdef ARB_STARVE_GUARD_EN
        force_if = (starve >= SMAX);
`else
        force_if = 1'b0;
`endif
        g_if = if_req && (!dm_req || force_if);
        if (g_if) starve = 0;
        else if (if_req) starve++;
        g      = c;
        free_c = c + LAT + 2;
        a       = g_if ? if_addr : dm_addr;
        g_maddr = (a / 8) * 8;
        idx     = int'((a / 8) % 64);
        g_we    = !g_if && dm_we;
        g_wdata = dm_wdata;
        if (g_if) g_data = (a % 8 == 4) ? {32'h0, sb_mem[idx][63:32]} : {32'h0, sb_mem[idx][31:0]};
        else if (dm_we) sb_mem[idx] = dm_wdata;
        else g_data = sb_mem[idx];
      end
      e_en   = (c == g + 1);
      e_busy = (c > g) && (c <= g + LAT + 1);
      e_ifv  = g_if && (c == g + LAT + 1);
      e_dmv  = !g_if && (c == g + LAT + 1);
      if (e_ifv) hold_if = g_data[31:0];
      if (e_dmv && !g_we) hold_dm = g_data;
      e_stall = (if_req && !e_ifv) || (dm_req && !e_dmv);
      @(negedge tb_clk);
      chk($sformatf("rnd mem_en c%0d", c), mem_en, e_en);
      chk($sformatf("rnd busy c%0d", c), busy, e_busy);
      chk($sformatf("rnd if_valid c%0d", c), if_valid, e_ifv);
      chk($sformatf("rnd dm_valid c%0d", c), dm_valid, e_dmv);
      chk($sformatf("rnd stall c%0d", c), stall, e_stall);
      chk($sformatf("rnd if_rdata c%0d", c), {32'h0, if_rdata}, {32'h0, hold_if});
      chk($sformatf("rnd dm_rdata c%0d", c), dm_rdata, hold_dm);
      if (e_en) begin
        chk($sformatf("rnd mem_addr c%0d", c), mem_addr, g_maddr);
        chk($sformatf("rnd mem_we c%0d", c), mem_we, g_we);
        if (g_we) chk($sformatf("rnd mem_wdata c%0d", c), mem_wdata, g_wdata);
      end
      next_cycle();
      if (e_ifv) if_req = 1'b0;
      if (e_dmv) dm_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
